// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser for a single asynchronous level.
// Latency: STAGES clock edges from d to q.
// No backpressure; the level is sampled on every clock edge.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Push-button debouncer: synchronises button_in, then qualifies each new level.
// Latency: SYNC_STAGES + STABLE_CYCLES edges from first sampling edge to button_out.
// No backpressure; shorter pulses and bounces are discarded.
module debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic button_in,
    output logic button_out
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_q;
    logic [CNT_W-1:0] cnt;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (button_in),
        .q      (sync_q)
    );

    // Any return to the current output level restarts qualification from zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt        <= '0;
            button_out <= 1'b0;
        end else if (sync_q == button_out) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            button_out <= sync_q;
            cnt        <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer: default instance plus a STABLE_CYCLES=1 instance sharing stimulus.
// Expected output transitions (edge number, level) are queued as stimulus is driven.
`timescale 1ns/1ps
module tb_debouncer;

    typedef struct {
        int   cyc;
        logic val;
    } ev_t;

    logic clk;
    logic resetn;
    logic button_in;
    logic out_main;
    logic out_min;

    int   cyc;
    int   checks;
    int   errors;
    logic last_in;
    logic prev_main;
    logic prev_min;
    ev_t  q_main[$];
    ev_t  q_min[$];

    debouncer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .button_in  (button_in),
        .button_out (out_main)
    );

    debouncer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (1)
    ) u_min (
        .clk        (clk),
        .resetn     (resetn),
        .button_in  (button_in),
        .button_out (out_min)
    );

    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard: every observed output transition must match the queue head.
    always @(negedge clk) begin
        if (out_main !== prev_main) begin
            checks = checks + 1;
            if (q_main.size() == 0) begin
                errors = errors + 1;
                $display("FAIL main_unexpected cycle %0d value %b, no transition expected", cyc, out_main);
            end else begin
                ev_t e;
                e = q_main.pop_front();
                if (e.cyc != cyc || e.val !== out_main) begin
                    errors = errors + 1;
                    $display("FAIL main_event cycle %0d value %b, expected cycle %0d value %b",
                             cyc, out_main, e.cyc, e.val);
                end
            end
            prev_main = out_main;
        end
        if (out_min !== prev_min) begin
            checks = checks + 1;
            if (q_min.size() == 0) begin
                errors = errors + 1;
                $display("FAIL min_unexpected cycle %0d value %b, no transition expected", cyc, out_min);
            end else begin
                ev_t e;
                e = q_min.pop_front();
                if (e.cyc != cyc || e.val !== out_min) begin
                    errors = errors + 1;
                    $display("FAIL min_event cycle %0d value %b, expected cycle %0d value %b",
                             cyc, out_min, e.cyc, e.val);
                end
            end
            prev_min = out_min;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_main(input int c, input logic v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        q_main.push_back(e);
    endtask

    task automatic push_min(input int c, input logic v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        q_min.push_back(e);
    endtask

    // Called just after a falling edge; the next rising edge samples the new level.
    task automatic set_in(input logic v, input bit main_exp);
        button_in = v;
        if (v !== last_in) push_min(cyc + 3, v);
        if (main_exp) push_main(cyc + 18, v);
        last_in = v;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            button_in = ~button_in;
            wait_cycles(49);
            checks = checks + 1;
            if (out_main !== 1'b0 || out_min !== 1'b0 || dut.cnt !== 4'd0) begin
                errors = errors + 1;
                $display("FAIL reset_hold step %0d main %b min %b cnt %0d, required 0 0 0",
                         i, out_main, out_min, dut.cnt);
            end
        end
        last_in = button_in;
        @(negedge clk);
        resetn = 1'b1;
        wait_cycles(5);
        checks = checks + 1;
        if (out_main !== 1'b0 || out_min !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_release main %b min %b, required 0 0", out_main, out_min);
        end
    endtask

    task automatic test_toggle;
        for (int i = 0; i < 4; i++) begin
            set_in(~last_in, 1'b1);
            wait_cycles(50);
        end
        checks = checks + 1;
        if (q_main.size() != 0 || q_min.size() != 0) begin
            errors = errors + 1;
            $display("FAIL toggle_drain pending main %0d min %0d, required 0 0", q_main.size(), q_min.size());
        end
    endtask

    task automatic test_glitch;
        set_in(1'b1, 1'b0);
        wait_cycles(10);
        set_in(1'b0, 1'b0);
        wait_cycles(30);
        set_in(1'b1, 1'b0);
        wait_cycles(15);
        set_in(1'b0, 1'b0);
        wait_cycles(30);
        checks = checks + 1;
        if (out_main !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL glitch_reject main %b, required 0", out_main);
        end
        set_in(1'b1, 1'b1);
        wait_cycles(16);
        set_in(1'b0, 1'b1);
        wait_cycles(40);
        checks = checks + 1;
        if (q_main.size() != 0 || q_min.size() != 0) begin
            errors = errors + 1;
            $display("FAIL glitch_drain pending main %0d min %0d, required 0 0", q_main.size(), q_min.size());
        end
    endtask

    task automatic test_bounce;
        set_in(1'b1, 1'b0);
        wait_cycles(3);
        set_in(1'b0, 1'b0);
        wait_cycles(3);
        set_in(1'b1, 1'b0);
        wait_cycles(3);
        set_in(1'b0, 1'b0);
        wait_cycles(3);
        set_in(1'b1, 1'b1);
        wait_cycles(30);
        checks = checks + 1;
        if (out_main !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL bounce_settled main %b, required 1", out_main);
        end
        set_in(1'b0, 1'b1);
        wait_cycles(30);
        checks = checks + 1;
        if (q_main.size() != 0 || q_min.size() != 0) begin
            errors = errors + 1;
            $display("FAIL bounce_drain pending main %0d min %0d, required 0 0", q_main.size(), q_min.size());
        end
    endtask

    task automatic test_reset_mid;
        set_in(1'b1, 1'b0);
        wait_cycles(12);
        #0.5;
        resetn = 1'b0;
        push_min(cyc + 1, 1'b0);
        #0.2;
        checks = checks + 1;
        if (out_main !== 1'b0 || out_min !== 1'b0 || dut.cnt !== 4'd0) begin
            errors = errors + 1;
            $display("FAIL reset_mid main %b min %b cnt %0d, required 0 0 0", out_main, out_min, dut.cnt);
        end
        wait_cycles(3);
        resetn = 1'b1;
        push_main(cyc + 18, 1'b1);
        push_min(cyc + 3, 1'b1);
        wait_cycles(25);
        #0.5;
        resetn = 1'b0;
        push_main(cyc + 1, 1'b0);
        push_min(cyc + 1, 1'b0);
        #0.2;
        checks = checks + 1;
        if (out_main !== 1'b0 || out_min !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_async main %b min %b, required 0 0", out_main, out_min);
        end
        @(negedge clk);
        resetn = 1'b1;
        push_main(cyc + 18, 1'b1);
        push_min(cyc + 3, 1'b1);
        wait_cycles(25);
        set_in(1'b0, 1'b1);
        wait_cycles(25);
        checks = checks + 1;
        if (q_main.size() != 0 || q_min.size() != 0) begin
            errors = errors + 1;
            $display("FAIL reset_mid_drain pending main %0d min %0d, required 0 0", q_main.size(), q_min.size());
        end
    endtask

    task automatic test_min_config;
        for (int i = 0; i < 8; i++) begin
            set_in((i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
            wait_cycles((i < 4) ? 1 : 2);
        end
        wait_cycles(10);
        checks = checks + 1;
        if (out_min !== 1'b0 || out_main !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL min_final min %b main %b, required 0 0", out_min, out_main);
        end
        checks = checks + 1;
        if (q_main.size() != 0 || q_min.size() != 0) begin
            errors = errors + 1;
            $display("FAIL min_drain pending main %0d min %0d, required 0 0", q_main.size(), q_min.size());
        end
    endtask

    initial begin
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        last_in   = 1'b0;
        prev_main = 1'b0;
        prev_min  = 1'b0;
        button_in = 1'b0;
        resetn    = 1'b1;
        #0.1;
        resetn    = 1'b0;
        test_reset;
        test_toggle;
        test_glitch;
        test_bounce;
        test_reset_mid;
        test_min_config;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debouncer.md
# debouncer

Single-channel push-button debouncer for board-level inputs. It synchronises an asynchronous mechanical button signal into the system clock domain. The output changes only after the synchronised input has held a new level for a programmable number of consecutive clock cycles. It sits between the raw pin and any edge-detect or control logic.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flip-flops; legal values are 2 or more.
- `STABLE_CYCLES`, default 16: number of consecutive cycles the synchronised input must differ from `button_out` before `button_out` updates; legal values are 1 or more.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `resetn`  input  1  asynchronous, active-low reset.
- `button_in`  input  1  raw asynchronous button level, which may bounce.
- `button_out`  output  1  debounced, registered button level.
- Port order is fixed as `clk`, `resetn`, `button_in`, `button_out`, because instances connect by position.

## Operation
- **Synchroniser.** `button_in` passes through a `SYNC_STAGES`-deep flip-flop chain. Its last stage is `sync_q`. No logic acts on `button_in` directly.
- **Counter.** Width is `$clog2(STABLE_CYCLES)`, with a minimum of 1 bit.
- **Per rising edge, when not in reset:**
  - If `sync_q == button_out`: the counter clears to 0.
  - If `sync_q != button_out` and the counter equals `STABLE_CYCLES-1`: `button_out` takes `sync_q` and the counter clears.
  - If `sync_q != button_out` otherwise: the counter increments.
- **Bounce rejection.** Any return of `sync_q` to the `button_out` level restarts qualification from 0. There is no partial credit across bounces.
- **Symmetry.** Rising and falling transitions are debounced identically.
- **No overflow.** The counter never exceeds `STABLE_CYCLES-1`.
- **Reset.**
  - While `resetn` is low, all synchroniser stages, the counter and `button_out` are held at 0, regardless of `button_in` or `clk`.
  - Assertion takes effect immediately (asynchronous).
  - Reset asserted mid-qualification discards the count. After release, a high `button_in` must requalify for the full latency before `button_out` rises.

## Timing
- **Latency.** Call the first rising edge that samples the new `button_in` level edge 1. If the level then stays stable, `button_out` changes on edge `SYNC_STAGES + STABLE_CYCLES`. With defaults this is edge 18.
- **Pulse rejection.** A level held for fewer than `STABLE_CYCLES` cycles at `sync_q` never reaches `button_out`. A level held for exactly `STABLE_CYCLES` cycles is accepted.
- **Output registering.** `button_out` is a flop output with no combinational path from `button_in`. It changes at most once per `STABLE_CYCLES` cycles.
- **Reset release.** Release is not synchronised inside the block. The first active edge after release samples `button_in` into stage 1.

## Structure
- No shared package is needed. The parameters are local to the block.
- The synchroniser is a natural sub-module: `sync_ff`, with parameter `STAGES`, an asynchronous active-low reset value of 0, and 1-bit data. It is reusable by other input blocks.
- The top level holds only the counter, the comparison and the `button_out` register.

## Test plan
All scenarios use defaults and a 2 ns clock period.
- **Reset hold.** Hold `resetn` low for 400 ns while `button_in` toggles every 100 ns → `button_out` stays 0 and the counter stays 0.
- **Steady toggling.** After reset release, toggle `button_in` every 100 ns (50 cycles) → `button_out` follows each level exactly 18 cycles (36 ns) after the first sampling edge, with a 50-cycle high/low period.
- **Glitch rejection.** With `button_out` at 0, pulse `button_in` high for 10 cycles, then return it low → `button_out` stays 0. A 16-cycle pulse at `sync_q` produces exactly one 16-cycle-wide output pulse.
- **Bounce burst.** Apply 5 toggles 3 cycles apart, then hold `button_in` high → `button_out` rises exactly 18 cycles after the final rising sample, with no intermediate transitions.
- **Reset mid-count.** With `button_in` high, assert `resetn` low 10 cycles into qualification, then release → `button_out` goes 0 immediately, then rises 18 cycles after the first post-release sampling edge.
- **Minimum configuration.** Set `STABLE_CYCLES=1` and toggle `button_in` → `button_out` follows `sync_q` with a latency of `SYNC_STAGES+1` edges.
